control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/riscv_pkg.sv | 62 ++++++
 rtl/opcode_classifier.sv | 32 +++
 rtl/control_fsm.sv | 195 +++++++++++++++++++
 tb/tb_control_fsm.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared encodings for the multi-cycle RV32 control path:
//   - FSM state codes (legacy-compatible 3-bit localparams)
//   - registered instruction class codes
//   - pc_src / alu_op / wb_sel select codes
//   - base opcode constants
//   - helper: legality of the func3 width field on loads/stores
package riscv_pkg;

  typedef logic [2:0] state_t;
  typedef logic [3:0] cls_t;

  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_TRAP   = 3'd5;

  // CLS_NONE is the cleared value held before the first DECODE.
  localparam cls_t CLS_NONE    = 4'd0;
  localparam cls_t CLS_R       = 4'd1;
  localparam cls_t CLS_IALU    = 4'd2;
  localparam cls_t CLS_LOAD    = 4'd3;
  localparam cls_t CLS_STORE   = 4'd4;
  localparam cls_t CLS_BRANCH  = 4'd5;
  localparam cls_t CLS_JAL     = 4'd6;
  localparam cls_t CLS_JALR    = 4'd7;
  localparam cls_t CLS_LUI     = 4'd8;
  localparam cls_t CLS_AUIPC   = 4'd9;
  localparam cls_t CLS_ILLEGAL = 4'd10;

  localparam logic [1:0] PC_PLUS4   = 2'b00;
  localparam logic [1:0] PC_IMM     = 2'b01;
  localparam logic [1:0] PC_RS1_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNC  = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Byte/half/word widths (000..010) plus the unsigned byte/half forms
  // (100, 101) are accepted; everything else is an illegal width.
  function automatic logic mem_width_legal(input logic [2:0] func3);
    return (func3 <= 3'b010) || (func3 == 3'b100) || (func3 == 3'b101);
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier
// Purely combinational decode of an instruction's opcode/func3 into the
// class code consumed by control_fsm.
// Ports:
//   opcode [6:0] : opcode field of the instruction word
//   func3  [2:0] : func3 field, only used to reject illegal encodings
//   cls    [3:0] : class code (CLS_ILLEGAL for anything not accepted)
module opcode_classifier
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  output cls_t       cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_IMM:    cls = CLS_IALU;
      OP_LOAD:   cls = mem_width_legal(func3) ? CLS_LOAD : CLS_ILLEGAL;
      OP_STORE:  cls = mem_width_legal(func3) ? CLS_STORE : CLS_ILLEGAL;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = (func3 == 3'b000) ? CLS_JALR : CLS_ILLEGAL;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      default:   cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// control_fsm
// Multi-cycle RV32 control unit: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Waits on imem/dmem ready are bounded by TIMEOUT cycles; a timeout or an
// illegal instruction parks the FSM in TRAP until reset.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   opcode, func3         : fields of the current instruction word
//   branch_taken          : ALU compare result, meaningful in EXEC
//   imem_ready/dmem_ready : memory handshakes
//   imem_req, dmem_req, dmem_we         : memory requests
//   ir_write, pc_write, reg_write       : datapath write strobes
//   pc_src, alu_src, alu_op, wb_sel     : datapath selects
//   trap                  : sticky trap indication
//   instret               : retired instruction count (wraps)
module control_fsm
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  pc_src,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [31:0] instret
);

  // The counter only ever holds 0..TIMEOUT-1: the cycle that would take it
  // to TIMEOUT goes to TRAP instead.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  cls_t             cls_q, cls_nxt, cls_dec;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic             retire;

  opcode_classifier u_classifier (
    .opcode (opcode),
    .func3  (func3),
    .cls    (cls_dec)
  );

  // Next-state, class capture, wait counter and retirement.
  always_comb begin
    state_nxt = state;
    cls_nxt   = cls_q;
    cnt_nxt   = '0;
    retire    = 1'b0;
    case (state)
      ST_FETCH: begin
        // Ready is checked first so it wins over a simultaneous timeout.
        if (imem_ready)                state_nxt = ST_DECODE;
        else if (wait_cnt == CNT_LAST) state_nxt = ST_TRAP;
        else                           cnt_nxt   = wait_cnt + 1'b1;
      end
      ST_DECODE: begin
        cls_nxt   = cls_dec;
        state_nxt = (cls_dec == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH: begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end
          CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
          default:             state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) begin
          if (cls_q == CLS_STORE) begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end else begin
            state_nxt = ST_WB;
          end
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = ST_TRAP;
        end else begin
          cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ST_WB: begin
        state_nxt = ST_FETCH;
        retire    = 1'b1;
      end
      ST_TRAP:  state_nxt = ST_TRAP;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      cls_q    <= CLS_NONE;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state    <= state_nxt;
      cls_q    <= cls_nxt;
      wait_cnt <= cnt_nxt;
      if (retire) instret <= instret + 32'd1;
    end
  end

  // Outputs depend only on state and the registered class (plus the
  // handshake/compare inputs that qualify a strobe), never on opcode.
  // rst_n gates everything so nothing is asserted while reset is held,
  // even though the reset state itself is FETCH.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    pc_src    = PC_PLUS4;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
          pc_write = imem_ready;
          pc_src   = PC_PLUS4;
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_BRANCH: begin
              alu_op   = ALU_CMP;
              pc_write = branch_taken;
              pc_src   = PC_IMM;
            end
            CLS_JAL: begin
              pc_write = 1'b1;
              pc_src   = PC_IMM;
            end
            CLS_JALR: begin
              pc_write = 1'b1;
              pc_src   = PC_RS1_IMM;
            end
            CLS_LOAD, CLS_STORE: begin
              alu_src = 1'b1;
              alu_op  = ALU_ADD;
            end
            CLS_R: begin
              alu_src = 1'b0;
              alu_op  = ALU_FUNC;
            end
            CLS_IALU: begin
              alu_src = 1'b1;
              alu_op  = ALU_FUNC;
            end
            CLS_LUI:   alu_op = ALU_PASSB;
            CLS_AUIPC: alu_op = ALU_ADD;
            default: ;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == CLS_STORE);
        end
        ST_WB: begin
          reg_write = 1'b1;
          case (cls_q)
            CLS_LOAD:          wb_sel = WB_MEM;
            CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
            default:           wb_sel = WB_ALU;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign trap = (state == ST_TRAP);

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm
// Directed scenarios for control_fsm. Each stimulus step pushes the output
// snapshot expected in that cycle; an independent monitor pops and compares
// on every falling edge.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'b0110011;
  logic [2:0]  func3 = 3'b000;
  logic        branch_taken = 1'b0;
  logic        imem_ready = 1'b1;
  logic        dmem_ready = 1'b1;
  logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write;
  logic [1:0]  pc_src, alu_op, wb_sel;
  logic        alu_src, trap;
  logic [31:0] instret;

  control_fsm #(.TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .func3        (func3),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .pc_src       (pc_src),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .wb_sel       (wb_sel),
    .trap         (trap),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write;
    logic [1:0]  pc_src;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        trap;
    logic [31:0] instret;
  } obs_t;

  typedef struct {
    obs_t  v;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  function automatic obs_t o_zero(input logic [31:0] ir);
    obs_t o;
    o = '0;
    o.instret = ir;
    return o;
  endfunction

  function automatic obs_t o_fetch(input logic rdy, input logic [31:0] ir);
    obs_t o;
    o = o_zero(ir);
    o.imem_req = 1'b1;
    o.ir_write = rdy;
    o.pc_write = rdy;
    return o;
  endfunction

  function automatic obs_t o_exec(input logic asrc, input logic [1:0] aop,
                                  input logic pcw, input logic [1:0] pcs,
                                  input logic [31:0] ir);
    obs_t o;
    o = o_zero(ir);
    o.alu_src  = asrc;
    o.alu_op   = aop;
    o.pc_write = pcw;
    o.pc_src   = pcs;
    return o;
  endfunction

  function automatic obs_t o_mem(input logic we, input logic [31:0] ir);
    obs_t o;
    o = o_zero(ir);
    o.dmem_req = 1'b1;
    o.dmem_we  = we;
    return o;
  endfunction

  function automatic obs_t o_wb(input logic [1:0] sel, input logic [31:0] ir);
    obs_t o;
    o = o_zero(ir);
    o.reg_write = 1'b1;
    o.wb_sel    = sel;
    return o;
  endfunction

  function automatic obs_t o_trap(input logic [31:0] ir);
    obs_t o;
    o = o_zero(ir);
    o.trap = 1'b1;
    return o;
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue the
  // outputs expected during that cycle.
  task automatic step(input logic r, input logic imr, input logic dmr,
                      input logic br, input obs_t e, input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n        = r;
    imem_ready   = imr;
    dmem_ready   = dmr;
    branch_taken = br;
    x.v   = e;
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, o_zero(32'd0), "rst_hold0");
    step(1'b0, 1'b1, 1'b1, 1'b0, o_zero(32'd0), "rst_hold1");
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    obs_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write,
               pc_src, alu_src, alu_op, wb_sel, trap, instret};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: got %h want %h (fields imem,dmem,we,ir,pc,reg,pcsrc,asrc,aop,wb,trap,instret)",
                   e.tag, act, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while imem_ready is already high
    do_reset();

    // ADD, ready immediately: F, D, E, WB
    opcode = 7'b0110011; func3 = 3'b000;
    step(1, 1, 1, 0, o_fetch(1, 0), "add_fetch");
    step(1, 1, 1, 0, o_zero(0), "add_decode");
    step(1, 1, 1, 0, o_exec(0, 2'b10, 0, 2'b00, 0), "add_exec");
    step(1, 1, 1, 0, o_wb(2'b00, 0), "add_wb");

    // LW, dmem_ready on third MEM cycle
    opcode = 7'b0000011; func3 = 3'b010;
    step(1, 1, 0, 0, o_fetch(1, 1), "lw_fetch");
    step(1, 1, 0, 0, o_zero(1), "lw_decode");
    step(1, 1, 0, 0, o_exec(1, 2'b00, 0, 2'b00, 1), "lw_exec");
    step(1, 1, 0, 0, o_mem(0, 1), "lw_mem1");
    step(1, 1, 0, 0, o_mem(0, 1), "lw_mem2");
    step(1, 1, 1, 0, o_mem(0, 1), "lw_mem3");
    step(1, 1, 1, 0, o_wb(2'b01, 1), "lw_wb");

    // BEQ taken
    opcode = 7'b1100011; func3 = 3'b000;
    step(1, 1, 1, 0, o_fetch(1, 2), "beq_t_fetch");
    step(1, 1, 1, 0, o_zero(2), "beq_t_decode");
    step(1, 1, 1, 1, o_exec(0, 2'b01, 1, 2'b01, 2), "beq_t_exec");
    // BEQ not taken, fetched right after
    step(1, 1, 1, 0, o_fetch(1, 3), "beq_n_fetch");
    step(1, 1, 1, 0, o_zero(3), "beq_n_decode");
    step(1, 1, 1, 0, o_exec(0, 2'b01, 0, 2'b01, 3), "beq_n_exec");

    // JAL
    opcode = 7'b1101111;
    step(1, 1, 1, 0, o_fetch(1, 4), "jal_fetch");
    step(1, 1, 1, 0, o_zero(4), "jal_decode");
    step(1, 1, 1, 0, o_exec(0, 2'b00, 1, 2'b01, 4), "jal_exec");
    step(1, 1, 1, 0, o_wb(2'b10, 4), "jal_wb");

    // imem_ready low 14 cycles, high on cycle 15: no trap; then SW
    opcode = 7'b0100011; func3 = 3'b010;
    for (int i = 0; i < 14; i++) step(1, 0, 1, 0, o_fetch(0, 5), "to_edge_wait");
    step(1, 1, 1, 0, o_fetch(1, 5), "to_edge_ready15");
    step(1, 1, 1, 0, o_zero(5), "sw_decode");
    step(1, 1, 1, 0, o_exec(1, 2'b00, 0, 2'b00, 5), "sw_exec");
    step(1, 1, 1, 0, o_mem(1, 5), "sw_mem");

    // JALR
    opcode = 7'b1100111; func3 = 3'b000;
    step(1, 1, 1, 0, o_fetch(1, 6), "jalr_fetch");
    step(1, 1, 1, 0, o_zero(6), "jalr_decode");
    step(1, 1, 1, 0, o_exec(0, 2'b00, 1, 2'b10, 6), "jalr_exec");
    step(1, 1, 1, 0, o_wb(2'b10, 6), "jalr_wb");

    // LUI
    opcode = 7'b0110111;
    step(1, 1, 1, 0, o_fetch(1, 7), "lui_fetch");
    step(1, 1, 1, 0, o_zero(7), "lui_decode");
    step(1, 1, 1, 0, o_exec(0, 2'b11, 0, 2'b00, 7), "lui_exec");
    step(1, 1, 1, 0, o_wb(2'b00, 7), "lui_wb");

    // SW interrupted by reset while in MEM
    opcode = 7'b0100011; func3 = 3'b010;
    step(1, 1, 0, 0, o_fetch(1, 8), "swr_fetch");
    step(1, 1, 0, 0, o_zero(8), "swr_decode");
    step(1, 1, 0, 0, o_exec(1, 2'b00, 0, 2'b00, 8), "swr_exec");
    step(1, 1, 0, 0, o_mem(1, 8), "swr_mem");
    step(0, 1, 0, 0, o_zero(0), "swr_rst_async");
    step(0, 1, 0, 0, o_zero(0), "swr_rst_hold");

    // Release with imem_ready low: imem_req in first cycle, then
    // 15 waiting cycles end in TRAP
    step(1, 0, 0, 0, o_fetch(0, 0), "to_first_after_rst");
    for (int i = 0; i < 14; i++) step(1, 0, 0, 0, o_fetch(0, 0), "to_wait");
    step(1, 1, 1, 0, o_trap(0), "to_trap0");
    step(1, 1, 1, 0, o_trap(0), "to_trap1");

    // Illegal opcode 1111111
    opcode = 7'b1111111; func3 = 3'b000;
    do_reset();
    step(1, 1, 1, 0, o_fetch(1, 0), "ill_fetch");
    step(1, 1, 1, 0, o_zero(0), "ill_decode");
    step(1, 1, 1, 0, o_trap(0), "ill_trap0");
    step(1, 1, 1, 0, o_trap(0), "ill_trap1");
    step(1, 1, 1, 0, o_trap(0), "ill_trap2");

    // Load with illegal width func3=011
    opcode = 7'b0000011; func3 = 3'b011;
    do_reset();
    step(1, 1, 1, 0, o_fetch(1, 0), "lbad_fetch");
    step(1, 1, 1, 0, o_zero(0), "lbad_decode");
    step(1, 1, 1, 0, o_trap(0), "lbad_trap");

    // JALR with func3 != 000
    opcode = 7'b1100111; func3 = 3'b001;
    do_reset();
    step(1, 1, 1, 0, o_fetch(1, 0), "jbad_fetch");
    step(1, 1, 1, 0, o_zero(0), "jbad_decode");
    step(1, 1, 1, 0, o_trap(0), "jbad_trap");

    // LHU (func3 101) is a legal load width
    opcode = 7'b0000011; func3 = 3'b101;
    do_reset();
    step(1, 1, 1, 0, o_fetch(1, 0), "lhu_fetch");
    step(1, 1, 1, 0, o_zero(0), "lhu_decode");
    step(1, 1, 1, 0, o_exec(1, 2'b00, 0, 2'b00, 0), "lhu_exec");
    step(1, 1, 1, 0, o_mem(0, 0), "lhu_mem");
    step(1, 1, 1, 0, o_wb(2'b01, 0), "lhu_wb");
    step(1, 0, 1, 0, o_fetch(0, 1), "lhu_after");

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
